// File: rtl/conv55_pkg.sv
// Shared constants for the 5x5 convolution window generator.
package conv55_pkg;

    localparam int KSIZE      = 5;
    localparam int NTAPS      = KSIZE * KSIZE;
    localparam int DEF_DATA_W = 8;
    localparam int WINDOW_W   = NTAPS * DEF_DATA_W;

endpackage

// File: rtl/conv55_line_buf.sv
// One image line of storage: combinational read and registered write at the same index,
// so a read in the write cycle returns the value from the previous row.
module conv55_line_buf #(
    parameter int IMG_W  = 32,
    parameter int DATA_W = 8,
    localparam int IDX_W = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [IMG_W];

    assign rd_data = mem[idx];

    // Write the new value at the current column; contents are never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wr_data;
        end
    end

endmodule

// File: rtl/conv55_window_gen.sv
// Raster-scan 5x5 sliding window generator feeding a 5x5 convolution unit.
module conv55_window_gen
    import conv55_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_pixel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NTAPS*DATA_W-1:0] out_window,
    output logic                    frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              accept, last_col, last_row, win_pixel;
    logic [DATA_W-1:0] line_rd [4];
    logic [DATA_W-1:0] line_wr [4];
    logic [DATA_W-1:0] taps_q [KSIZE][KSIZE];

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign last_col   = (col_q == CW'(IMG_W - 1));
    assign last_row   = (row_q == RW'(IMG_H - 1));
    assign win_pixel  = (row_q >= RW'(KSIZE - 1)) && (col_q >= CW'(KSIZE - 1));
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

    // Line buffers form a vertical shift chain: line0 holds the newest previous row.
    assign line_wr[0] = in_pixel;
    assign line_wr[1] = line_rd[0];
    assign line_wr[2] = line_rd[1];
    assign line_wr[3] = line_rd[2];

    for (genvar i = 0; i < 4; i++) begin : g_line
        conv55_line_buf #(
            .IMG_W  (IMG_W),
            .DATA_W (DATA_W)
        ) u_line (
            .clk     (clk),
            .wr_en   (accept),
            .idx     (col_q),
            .wr_data (line_wr[i]),
            .rd_data (line_rd[i])
        );
    end

    // Next-state for position counters, window valid and end-of-frame pulse.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        if (accept) begin
            out_valid_d  = win_pixel;
            frame_done_d = last_col && last_row;
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Tap array shifts left each accepted pixel; column 4 takes the new vertical slice.
    // Row-straddling windows are garbage but never flagged valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) begin
                    taps_q[r][c] <= taps_q[r][c+1];
                end
            end
            taps_q[0][KSIZE-1] <= line_rd[3];
            taps_q[1][KSIZE-1] <= line_rd[2];
            taps_q[2][KSIZE-1] <= line_rd[1];
            taps_q[3][KSIZE-1] <= line_rd[0];
            taps_q[4][KSIZE-1] <= in_pixel;
        end
    end

    // Flatten taps; forced to zero when no window is presented so reset shows zeros.
    always_comb begin
        out_window = '0;
        if (out_valid_q) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE; c++) begin
                    out_window[(r*KSIZE+c)*DATA_W +: DATA_W] = taps_q[r][c];
                end
            end
        end
    end

endmodule

// File: doc/conv55_window_gen.md
CONV55_WINDOW_GEN -- requirements
Module: conv55_window_gen

Interface
REQ-001 Parameter IMG_W, default 32, pixels per image row (SHALL be >= 5).
REQ-002 Parameter IMG_H, default 32, rows per frame (SHALL be >= 5).
REQ-003 Parameter DATA_W, default 8, pixel width in bits.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  in_pixel holds a valid pixel.
REQ-007 in_ready  output  1  the block accepts a pixel this cycle.
REQ-008 in_pixel  input  DATA_W  raster-order pixel, row-major, left to right.
REQ-009 out_valid  output  1  out_window holds a complete 5x5 window.
REQ-010 out_ready  input  1  the downstream conv unit takes the window this cycle.
REQ-011 out_window  output  25*DATA_W  tap k = r*5+c at bits [k*DATA_W +: DATA_W]; r=0 is the oldest row, c=0 the leftmost column; taps map directly to in_data_0..in_data_24 of the 5x5 conv unit.
REQ-012 frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.

Function
REQ-013 The block SHALL accept a pixel on every cycle where in_valid && in_ready.
REQ-014 in_ready SHALL equal !out_valid || out_ready, combinationally.
REQ-015 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance per accepted pixel. col wraps to 0 at IMG_W-1 and increments row. row wraps to 0 at IMG_H-1 together with col.
REQ-016 The block SHALL keep 4 line buffers of IMG_W entries holding the previous 4 rows, plus a 5x5 tap register array that shifts left by one column per accepted pixel.
REQ-017 On acceptance, the new column SHALL be {line3[col], line2[col], line1[col], line0[col], in_pixel} in rows r=0..4. The line buffers SHALL shift down at index col in the same cycle (line0 <= in_pixel, line1 <= line0, and so on).
REQ-018 Taps SHALL be loaded from each accepted pixel regardless of row/col. Taps spanning a row boundary are garbage and SHALL be masked by REQ-019 only.
REQ-019 When a pixel is accepted at (row>=4, col>=4), out_valid SHALL be 1 on the next cycle, with tap 24 equal to that pixel and tap 0 equal to pixel (row-4, col-4). Latency is 1 cycle.
REQ-020 out_valid and out_window SHALL hold stable while out_valid && !out_ready.
REQ-021 When out_valid && out_ready and the same cycle accepts no window-producing pixel, out_valid SHALL drop to 0 next cycle.
REQ-022 Simultaneous out_ready and a window-producing acceptance SHALL yield back-to-back windows at one window per cycle, with no bubble.
REQ-023 Each frame SHALL produce exactly (IMG_W-4)*(IMG_H-4) windows.
REQ-024 frame_done SHALL pulse on the cycle after acceptance of pixel (IMG_H-1, IMG_W-1). The next frame SHALL start at (0,0) without any gap cycle.
REQ-025 Pixel values SHALL pass through unmodified. No arithmetic is performed on them.

Reset
REQ-026 While rst=1: row=0, col=0, out_valid=0, frame_done=0, out_window=0, and in_ready=1 per REQ-014.
REQ-027 Line buffer and tap contents need not be cleared. REQ-019 gating SHALL guarantee no stale window is emitted.
REQ-028 Reset asserted mid-frame SHALL discard any pending window and restart at pixel (0,0) on the first cycle after rst deasserts.

Structure
REQ-029 Shared package conv55_pkg SHALL hold KSIZE=5, NTAPS=25, DATA_W default, and the window-width constant NTAPS*DATA_W.
REQ-030 One sub-module conv55_line_buf SHALL implement a single line buffer (IMG_W x DATA_W, read-before-write at one index per cycle). It is instantiated 4 times.

Verification
REQ-031 IMG_W=IMG_H=8, pixel value = row*8+col, in_valid=1, out_ready=1 -> first out_valid one cycle after pixel 36 is accepted; tap0=0, tap12=18, tap24=36.
REQ-032 Same stream -> exactly 16 windows per frame; the last window has tap0=27 and tap24=63; frame_done pulses once.
REQ-033 Hold out_ready=0 for 5 cycles on the first window -> in_ready=0, out_window stable at taps 0/24 = 0/36, and no pixel is lost. After release, the second window has tap24=37.
REQ-034 Assert rst for 1 cycle after pixel 40 -> out_valid=0. Restarting the ramp reproduces REQ-031 exactly.
REQ-035 Two consecutive frames with no gap -> the second frame's first window appears after 37 more accepted pixels, with tap0=0 and tap24=36.
REQ-036 Random in_valid and out_ready at 50% -> the window sequence matches a reference model, and the window count equals 16 per frame.
